uart_image_loader: RTL and testbench
====================================

// Module: uart_image_loader
// PURPOSE
//   Upstream writer for the frame-buffer BRAM: takes a byte stream from the UART
//   receiver, detects a 2-byte sync header and writes one RGB111 pixel per byte into
//   the BRAM write port, in raster order from address 0.
//   Produces the 00000RGB layout the VGA display stage reads at y*H_RES+x.
// PARAMETERS
//   H_RES           640        pixels per line
//   V_RES           480        lines per frame; N = H_RES*V_RES pixels per frame
//   SYNC_A          8'hAA      first header byte
//   SYNC_B          8'h55      second header byte
//   TIMEOUT_CYCLES  2_500_000  max idle clocks between bytes once header started (100 ms @25 MHz)
// PORTS
//   clk_25mhz    in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   rx_valid     in   1   one-cycle strobe: rx_data holds a received byte
//   rx_data      in   8   received byte
//   bram_we      out  1   BRAM write enable, one cycle per pixel
//   bram_addr    out  19  BRAM write address, 0..N-1
//   bram_wdata   out  8   pixel byte {5'b0, R, G, B}
//   loading      out  1   high while in SYNC, RECV or CHECK
//   frame_done   out  1   one-cycle pulse, full frame accepted
//   error        out  1   sticky: timeout or checksum failure
//   pixel_count  out  19  pixels written in current/last frame
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-frame aborts at once;
//     partially written BRAM contents are left as they are.
//   - States IDLE, SYNC, RECV, CHECK (CHECK only with the macro), DONE. Transitions fire on rx_valid only.
//   - IDLE: byte==SYNC_A -> SYNC; any other byte is ignored.
//   - SYNC: byte==SYNC_B -> RECV, pixel_count<=0, error<=0; byte==SYNC_A -> stay SYNC;
//     any other byte -> IDLE.
//   - RECV: each byte is written with 1-cycle latency.
//     - Next cycle: bram_we=1, bram_addr=pixel_count, bram_wdata={5'b0,rx_data[2:0]}.
//     - pixel_count increments. Upper bits [7:3] are discarded with no error.
//   - RECV: rx_valid on consecutive cycles gives one write per cycle; no stall, no loss.
//   - Last pixel (pixel_count==N-1 at accept) -> DONE, or CHECK with the macro.
//     - Address never wraps. pixel_count ends at N.
//   - DONE: lasts one cycle, then -> IDLE. bram_we is 0 outside the write cycles.
//   - Timeout: counter clears on every rx_valid and runs in SYNC, RECV and CHECK.
//     - Reaching TIMEOUT_CYCLES-1 -> error=1, state IDLE, pixel_count held.
//     - rx_valid on the same cycle as timeout: the byte wins and the counter clears.
//   - frame_done and bram_we are registered. error clears only on a new SYNC_B accept or reset.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined:
//     - One extra byte follows the pixels: XOR of all N raw 8-bit pixel bytes. RECV -> CHECK.
//     - Match: frame_done pulses the cycle after the checksum byte, then DONE.
//     - Mismatch: error=1, no frame_done, then IDLE. The checksum byte is never written to BRAM.
//   LOADER_CHECKSUM_EN undefined:
//     - No CHECK state. frame_done pulses in the same cycle as the last bram_we (addr N-1).
// TESTING (H_RES=4, V_RES=2, N=8, TIMEOUT_CYCLES=16 unless stated)
//   1 Assert reset mid-RECV -> next cycle all outputs 0. Next AA 55 header starts at addr 0.
//   2 AA 55 then 01..08 -> 8 writes at addr 0..7, data 01..07 then 00.
//     - Without macro: frame_done one pulse together with the addr-7 write; pixel_count=8.
//   3 AA 12 01 -> no write, IDLE.
//     - AA AA 55 01 -> accepted; write addr 0 data 01.
//   4 AA 55 01 02 03 then 16 idle cycles -> error=1, loading=0, pixel_count=3.
//     - Next AA 55 -> error=0.
//   5 AA 55 then 8 bytes on 8 consecutive cycles -> bram_we high 8 consecutive cycles,
//     addrs 0..7 in order.
//   6 With LOADER_CHECKSUM_EN: 01..08 then 08 -> frame_done, error=0.
//     - 01..08 then 00 -> error=1, no frame_done, 8 writes only.

Source files
------------

// File: rtl/uart_image_loader.sv
// uart_image_loader: turns a UART byte stream into frame-buffer BRAM writes.
// A two-byte sync header (SYNC_A, SYNC_B) starts a frame. Each following byte
// becomes one RGB111 pixel {5'b0, R, G, B}, written in raster order from
// address 0. An inter-byte timeout aborts a stalled frame.
// Optional build macro LOADER_CHECKSUM_EN: a trailing XOR checksum byte is
// verified before the frame is reported as done.
module uart_image_loader #(
   parameter int          H_RES          = 640,
   parameter int          V_RES          = 480,
   parameter logic [7:0]  SYNC_A         = 8'hAA,
   parameter logic [7:0]  SYNC_B         = 8'h55,
   parameter int          TIMEOUT_CYCLES = 2_500_000
) (
   input  logic        clk_25mhz,
   input  logic        reset,
   // rx_valid is a one-cycle strobe with no backpressure: every byte
   // presented with rx_valid=1 is consumed in that same cycle.
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        bram_we,
   output logic [18:0] bram_addr,
   output logic [7:0]  bram_wdata,
   output logic        loading,
   output logic        frame_done,
   output logic        error,
   output logic [18:0] pixel_count
);

   localparam int              N        = H_RES * V_RES;
   localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [18:0]     LAST_PIX = 19'(N - 1);
   localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_RECV, S_CHECK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_RECV, S_DONE} state_t;
`endif

   state_t          state;
   state_t          state_next;
   logic [TW-1:0]   timer;
   logic            timeout_hit;
   logic            hdr_accept;
   logic            pix_accept;
   logic            last_pix;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]      xsum;
   logic            chk_ok;
   logic            chk_bad;
   assign chk_ok  = (state == S_CHECK) && rx_valid && (rx_data == xsum);
   assign chk_bad = (state == S_CHECK) && rx_valid && (rx_data != xsum);
`endif

   assign hdr_accept  = (state == S_SYNC) && rx_valid && (rx_data == SYNC_B);
   assign pix_accept  = (state == S_RECV) && rx_valid;
   assign last_pix    = pix_accept && (pixel_count == LAST_PIX);
   // A byte arriving in the timeout cycle wins, so rx_valid masks the abort.
   assign timeout_hit = loading && !rx_valid && (timer == TO_LAST);

   // State register.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state decode and the loading flag.
   always_comb begin
      state_next = state;
      loading    = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_valid && (rx_data == SYNC_A)) state_next = S_SYNC;
         end
         S_SYNC: begin
            loading = 1'b1;
            if (rx_valid) begin
               if (rx_data == SYNC_B)      state_next = S_RECV;
               else if (rx_data != SYNC_A) state_next = S_IDLE;
            end
         end
         S_RECV: begin
            loading = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (last_pix) state_next = S_CHECK;
`else
            if (last_pix) state_next = S_DONE;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            loading = 1'b1;
            if (chk_ok)       state_next = S_DONE;
            else if (chk_bad) state_next = S_IDLE;
         end
`endif
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (timeout_hit) state_next = S_IDLE;
   end

   // Inter-byte idle counter; only runs while a frame is being loaded.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset)                                     timer <= '0;
      else if (rx_valid || !loading || timer == TO_LAST) timer <= '0;
      else                                           timer <= timer + TW'(1);
   end

   // BRAM write port, pixel counter and status flags.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         bram_we     <= 1'b0;
         bram_addr   <= '0;
         bram_wdata  <= '0;
         frame_done  <= 1'b0;
         error       <= 1'b0;
         pixel_count <= '0;
      end else begin
         bram_we    <= pix_accept;
         frame_done <= 1'b0;
         if (hdr_accept) begin
            pixel_count <= '0;
            error       <= 1'b0;
         end
         if (pix_accept) begin
            bram_addr   <= pixel_count;
            bram_wdata  <= {5'b0, rx_data[2:0]};
            pixel_count <= pixel_count + 19'd1;
         end
`ifdef LOADER_CHECKSUM_EN
         if (chk_ok)  frame_done <= 1'b1;
         if (chk_bad) error      <= 1'b1;
`else
         if (last_pix) frame_done <= 1'b1;
`endif
         if (timeout_hit) error <= 1'b1;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running XOR of the raw pixel bytes of the current frame.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset)           xsum <= '0;
      else if (hdr_accept) xsum <= '0;
      else if (pix_accept) xsum <= xsum ^ rx_data;
   end
`endif

endmodule

// File: tb/tb_uart_image_loader.sv
// tb_uart_image_loader: directed cases plus a randomized byte stream, checked
// every cycle against a byte-level behavioural model of the loader.
module tb_uart_image_loader;

   localparam int         H_RES = 4;
   localparam int         V_RES = 2;
   localparam int         N     = H_RES * V_RES;
   localparam int         TO    = 16;
   localparam logic [7:0] SA    = 8'hAA;
   localparam logic [7:0] SB    = 8'h55;

   // ---------------- clock / reset ----------------
   logic        clk_25mhz = 1'b0;
   logic        reset     = 1'b1;
   logic        rx_valid  = 1'b0;
   logic [7:0]  rx_data   = 8'h00;
   logic        bram_we;
   logic [18:0] bram_addr;
   logic [7:0]  bram_wdata;
   logic        loading;
   logic        frame_done;
   logic        error;
   logic [18:0] pixel_count;

   always #20 clk_25mhz = ~clk_25mhz;

   uart_image_loader #(
      .H_RES(H_RES), .V_RES(V_RES), .SYNC_A(SA), .SYNC_B(SB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_25mhz(clk_25mhz), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
      .loading(loading), .frame_done(frame_done), .error(error),
      .pixel_count(pixel_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 scanning, 1 saw first sync byte, 2 taking pixels,
   // 3 waiting for checksum, 4 frame finished (one cycle)
   int          m_phase;
   int          m_px;
   int          m_quiet;
   logic        m_err;
   logic        m_we;
   logic        m_fd;
   logic [18:0] m_addr;
   logic [7:0]  m_wdata;
   logic [7:0]  m_xs;

   task automatic model_reset();
      m_phase = 0; m_px = 0; m_quiet = 0; m_err = 1'b0;
      m_we = 1'b0; m_fd = 1'b0; m_addr = '0; m_wdata = '0; m_xs = '0;
   endtask

   // Advance by one clock given this cycle's input; leaves the outputs
   // expected after the coming edge.
   task automatic model_step(input logic v, input logic [7:0] b);
      bit was_loading;
      was_loading = (m_phase >= 1 && m_phase <= 3);
      m_we = 1'b0;
      m_fd = 1'b0;
      if (v) m_quiet = 0;
      case (m_phase)
         0: if (v && b == SA) m_phase = 1;
         1: if (v) begin
               if (b == SB) begin
                  m_phase = 2; m_px = 0; m_err = 1'b0; m_xs = '0;
               end else if (b != SA) m_phase = 0;
            end
         2: if (v) begin
               m_we = 1'b1;
               m_addr = 19'(m_px);
               m_wdata = {5'b0, b[2:0]};
               m_xs = m_xs ^ b;
               m_px++;
               if (m_px == N) begin
`ifdef LOADER_CHECKSUM_EN
                  m_phase = 3;
`else
                  m_phase = 4;
                  m_fd = 1'b1;
`endif
               end
            end
         3: if (v) begin
               if (b == m_xs) begin m_fd = 1'b1; m_phase = 4; end
               else begin m_err = 1'b1; m_phase = 0; end
            end
         default: m_phase = 0;
      endcase
      if (!v && was_loading) begin
         m_quiet++;
         if (m_quiet == TO) begin
            m_err = 1'b1; m_phase = 0; m_quiet = 0;
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [26:0] exp_q[$];
   logic [26:0] got_q[$];
   int fd_cnt;
   int fd_with_last;
   int we_run;
   int we_max;

   task automatic clear_log();
      exp_q.delete(); got_q.delete();
      fd_cnt = 0; fd_with_last = 0; we_run = 0; we_max = 0;
   endtask

   task automatic compare_log(input string name);
      check({name, "_nwrites"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0)
         check({name, "_write"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
   endtask

   // Compare process: outputs settle after the rising edge, so check on the falling one.
   always @(negedge clk_25mhz) begin
      if (reset) begin
         check("rst_we", bram_we, 0);
         check("rst_fd", frame_done, 0);
         check("rst_err", error, 0);
         check("rst_loading", loading, 0);
         check("rst_px", pixel_count, 0);
         check("rst_addr", bram_addr, 0);
         check("rst_wdata", bram_wdata, 0);
         model_reset();
      end else begin
         check("we", bram_we, m_we);
         check("frame_done", frame_done, m_fd);
         check("error", error, m_err);
         check("loading", loading, (m_phase >= 1 && m_phase <= 3));
         check("pixel_count", pixel_count, m_px);
         if (m_we) begin
            check("addr", bram_addr, m_addr);
            check("wdata", bram_wdata, m_wdata);
         end
         if (bram_we) begin
            got_q.push_back({bram_addr, bram_wdata});
            we_run++;
            if (we_run > we_max) we_max = we_run;
         end else begin
            we_run = 0;
         end
         if (frame_done) begin
            fd_cnt++;
            if (bram_we && bram_addr == 19'(N - 1)) fd_with_last++;
         end
         model_step(rx_valid, rx_data);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] b);
      @(posedge clk_25mhz); #1;
      rx_valid = 1'b1;
      rx_data  = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_25mhz); #1;
         rx_valid = 1'b0;
         rx_data  = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic do_reset();
      @(posedge clk_25mhz); #1;
      reset    = 1'b1;
      rx_valid = 1'b0;
      #2;
      check("async_rst_we", bram_we, 0);
      check("async_rst_loading", loading, 0);
      check("async_rst_px", pixel_count, 0);
      @(posedge clk_25mhz); #1;
      reset = 1'b0;
   endtask

   task automatic send_frame();
      logic [7:0] x;
      logic [7:0] p;
      x = '0;
      send(SA); send(SB);
      for (int i = 0; i < N; i++) begin
         p = 8'($urandom_range(0, 255));
         x = x ^ p;
         send(p);
      end
`ifdef LOADER_CHECKSUM_EN
      send(x);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r;
      logic [7:0] b;
      reset = 1'b1;
      clear_log();
      repeat (3) @(posedge clk_25mhz);
      #1 reset = 1'b0;
      idle(2);
      check("init_px", pixel_count, 0);
      check("init_err", error, 0);

      // Full frame of bytes 01..08 on consecutive cycles.
      clear_log();
      send(SA); send(SB);
      for (int i = 1; i <= N; i++) send(8'(i));
`ifdef LOADER_CHECKSUM_EN
      send(8'h08);
`endif
      idle(3);
      for (int i = 0; i < N; i++) exp_q.push_back({19'(i), 8'((i + 1) & 7)});
      compare_log("frame");
      check("frame_fd_cnt", fd_cnt, 1);
      check("frame_px", pixel_count, N);
      check("frame_err", error, 0);
      check("frame_we_run", we_max, N);
`ifndef LOADER_CHECKSUM_EN
      check("frame_fd_with_last", fd_with_last, 1);
`endif

      // Bad second header byte, then a repeated first sync byte.
      clear_log();
      send(SA); send(8'h12); send(8'h01);
      idle(3);
      check("badhdr_nwrites", got_q.size(), 0);
      check("badhdr_loading", loading, 0);
      send(SA); send(SA); send(SB); send(8'h01);
      idle(2);
      exp_q.push_back({19'd0, 8'h01});
      compare_log("rehdr");
      idle(20);
      check("rehdr_timeout_err", error, 1);

      // Timeout after three pixels, then a new header clears error.
      clear_log();
      send(SA); send(SB); send(8'h01); send(8'h02); send(8'h03);
      idle(17);
      check("to_err", error, 1);
      check("to_loading", loading, 0);
      check("to_px", pixel_count, 3);
      send(SA); send(SB);
      idle(1);
      check("to_clear_err", error, 0);
      check("to_loading2", loading, 1);

      // Reset in the middle of a frame, then a fresh frame starts at 0.
      send(8'h01); send(8'h02);
      do_reset();
      clear_log();
      send(SA); send(SB); send(8'h05);
      idle(2);
      exp_q.push_back({19'd0, 8'h05});
      compare_log("after_rst");
      idle(20);

`ifdef LOADER_CHECKSUM_EN
      // Wrong checksum: pixels written, no frame_done, error raised.
      clear_log();
      send(SA); send(SB);
      for (int i = 1; i <= N; i++) send(8'(i));
      send(8'h00);
      idle(3);
      check("badsum_fd_cnt", fd_cnt, 0);
      check("badsum_err", error, 1);
      check("badsum_nwrites", got_q.size(), N);
      check("badsum_loading", loading, 0);
`endif

      // Randomized stream: sync-heavy bytes, random gaps, occasional resets.
      clear_log();
      for (int k = 0; k < 600; k++) begin
         r = $urandom_range(0, 99);
         if (r < 5) begin
            send_frame();
         end else begin
            if (r < 18)      b = SA;
            else if (r < 30) b = SB;
            else             b = 8'($urandom_range(0, 255));
            send(b);
         end
         r = $urandom_range(0, 99);
         if (r < 60)      ;
         else if (r < 92) idle($urandom_range(1, 3));
         else if (r < 98) idle($urandom_range(12, 18));
         else             do_reset();
      end
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #20_000_000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
